// File: rtl/ysyx_22041752_axi_pkg.sv
// Shared AXI4 definitions for the SRAM responder: channel widths,
// burst/response codes, FSM state enums and address-step helpers.
package ysyx_22041752_axi_pkg;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  function automatic logic [ADDR_W-1:0] axi_step(
    input logic [ADDR_W-1:0] a,
    input logic [1:0]        burst,
    input logic [2:0]        size
  );
    if (burst == BURST_INCR)
      return a + (32'd1 << size);
    return a;
  endfunction

  // WRAP, the reserved burst code and sizes wider than the bus
  // are all refused with SLVERR.
  function automatic logic [1:0] proto_resp(
    input logic [1:0] burst,
    input logic [2:0] size
  );
    if ((burst == BURST_FIXED || burst == BURST_INCR)
        && size <= 3'd3)
      return RESP_OKAY;
    return RESP_SLVERR;
  endfunction

endpackage

// File: rtl/ysyx_22041752_axi_sram_mem.sv
// DEPTH x 64 memory: async read port, byte-masked write port.
// Read sees the old word when the same word is written that cycle.
module ysyx_22041752_axi_sram_mem #(
  parameter int DEPTH = 65536,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic [AW-1:0] raddr_i,
  output logic [63:0]   rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [63:0]   wdata_i,
  input  logic [7:0]    wstrb_i
);

  logic [63:0] mem_q [DEPTH];

  assign rdata_o = mem_q[raddr_i];

  always_ff @(posedge clock) begin
    if (we_i) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb_i[b])
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/ysyx_22041752_axi_sram_slave.sv
// AXI4 responder backing the core master port with an on-chip SRAM.
// Independent read (AR/R) and write (AW/W/B) FSMs; INCR/FIXED only.
// Ports: clock, reset (async, low), AXI4 AW/W/B/AR/R channels.
// YSYX_22041752_AXI_DECERR_EN: out-of-range beats answer DECERR.
module ysyx_22041752_axi_sram_slave
  import ysyx_22041752_axi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          DEPTH     = 65536,
  parameter int          RD_LAT    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  output logic              rvalid,
  input  logic              rready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd8;
`ifdef YSYX_22041752_AXI_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  function automatic logic [AW-1:0] widx(
    input logic [31:0] a
  );
    return AW'((a - ADDR_BASE) >> 3);
  endfunction

  function automatic logic in_range(
    input logic [31:0] a
  );
    logic [31:0] off;
    off = a - ADDR_BASE;
    return {1'b0, off} < SPAN;
  endfunction

  function automatic logic [1:0] beat_resp(
    input logic [31:0] a,
    input logic [1:0]  burst,
    input logic [2:0]  size
  );
    logic [1:0] r;
    r = proto_resp(burst, size);
    if (r == RESP_OKAY && DECERR_EN && !in_range(a))
      r = RESP_DECERR;
    return r;
  endfunction

  r_state_e     r_state_q, r_state_d;
  logic [3:0]   rid_q, rid_d;
  logic [31:0]  raddr_q, raddr_d;
  logic [7:0]   rlen_q, rlen_d;
  logic [2:0]   rsize_q, rsize_d;
  logic [1:0]   rburst_q, rburst_d;
  logic [7:0]   rbeat_q, rbeat_d;
  logic [3:0]   rwait_q, rwait_d;
  logic [63:0]  rdata_q, rdata_d;
  logic [1:0]   rresp_q, rresp_d;
  logic         r_load;
  logic [31:0]  rd_a;
  logic [1:0]   rd_b;
  logic [2:0]   rd_s;
  logic [63:0]  mem_rdata;

  w_state_e     w_state_q, w_state_d;
  logic [3:0]   wid_q, wid_d;
  logic [31:0]  waddr_q, waddr_d;
  logic [7:0]   wlen_q, wlen_d;
  logic [2:0]   wsize_q, wsize_d;
  logic [1:0]   wburst_q, wburst_d;
  logic [7:0]   wbeat_q, wbeat_d;
  logic [1:0]   bresp_q, bresp_d;
  logic [1:0]   w_resp;
  logic [1:0]   w_bresp;
  logic         mem_we;

  // rdata is loaded when a beat is first presented, so it holds
  // through rready stalls even if that word is rewritten meanwhile.
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rbeat_d   = rbeat_q;
    rwait_d   = rwait_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_load    = 1'b0;
    rd_a      = raddr_q;
    rd_b      = rburst_q;
    rd_s      = rsize_q;
    unique case (r_state_q)
      R_IDLE: begin
        rd_a = araddr;
        rd_b = arburst;
        rd_s = arsize;
        if (arvalid) begin
          rid_d    = arid;
          raddr_d  = araddr;
          rlen_d   = arlen;
          rsize_d  = arsize;
          rburst_d = arburst;
          rbeat_d  = '0;
          rwait_d  = '0;
          if (RD_LAT == 0) begin
            r_state_d = R_DATA;
            r_load    = 1'b1;
          end else begin
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        rwait_d = rwait_q + 4'd1;
        if (rwait_q == 4'(RD_LAT - 1)) begin
          r_state_d = R_DATA;
          r_load    = 1'b1;
        end
      end
      R_DATA: begin
        rd_a = axi_step(raddr_q, rburst_q, rsize_q);
        if (rready) begin
          if (rbeat_q == rlen_q) begin
            r_state_d = R_IDLE;
          end else begin
            raddr_d = rd_a;
            rbeat_d = rbeat_q + 8'd1;
            r_load  = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_load) begin
      rresp_d = beat_resp(rd_a, rd_b, rd_s);
      rdata_d = (rresp_d == RESP_OKAY) ? mem_rdata : '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rbeat_q   <= '0;
      rwait_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rbeat_q   <= rbeat_d;
      rwait_q   <= rwait_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // bresp accumulates the worst code seen across the burst;
  // a wlast that disagrees with the beat count marks SLVERR.
  always_comb begin
    w_state_d = w_state_q;
    wid_d     = wid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    wbeat_d   = wbeat_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    w_resp    = RESP_OKAY;
    w_bresp   = RESP_OKAY;
    unique case (w_state_q)
      W_IDLE: begin
        if (awvalid) begin
          wid_d     = awid;
          waddr_d   = awaddr;
          wlen_d    = awlen;
          wsize_d   = awsize;
          wburst_d  = awburst;
          wbeat_d   = '0;
          bresp_d   = RESP_OKAY;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          w_resp  = beat_resp(waddr_q, wburst_q, wsize_q);
          mem_we  = (w_resp == RESP_OKAY);
          w_bresp = w_resp;
          if (wlast != (wbeat_q == wlen_q)
              && w_resp == RESP_OKAY)
            w_bresp = RESP_SLVERR;
          if (w_bresp > bresp_q)
            bresp_d = w_bresp;
          if (wbeat_q == wlen_q) begin
            w_state_d = W_RESP;
          end else begin
            wbeat_d = wbeat_q + 8'd1;
            waddr_d = axi_step(waddr_q, wburst_q, wsize_q);
          end
        end
      end
      W_RESP: begin
        if (bready)
          w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      wbeat_q   <= '0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      wbeat_q   <= wbeat_d;
      bresp_q   <= bresp_d;
    end
  end

  ysyx_22041752_axi_sram_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clock   (clock),
    .raddr_i (widx(rd_a)),
    .rdata_o (mem_rdata),
    .we_i    (mem_we),
    .waddr_i (widx(waddr_q)),
    .wdata_i (wdata),
    .wstrb_i (wstrb)
  );

  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_DATA);
  assign rlast   = rvalid && (rbeat_q == rlen_q);
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  assign awready = (w_state_q == W_IDLE);
  assign wready  = (w_state_q == W_DATA);
  assign bvalid  = (w_state_q == W_RESP);
  assign bid     = wid_q;
  assign bresp   = bresp_q;

endmodule
